// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if -- request/result bundle for the multiply/divide unit.
//   op_a, op_b : operands (dividend / divisor for divides)
//   op         : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   start      : one-cycle request, operands sampled on that edge
//   hi_wr/lo_wr/wr_data : MTHI / MTLO writes
//   hi, lo     : result registers
//   busy, done : operation in progress / one-cycle completion pulse
interface mult_div_unit_if;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  op;
  logic        start;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wr_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output op_a, op_b, op, start, hi_wr, lo_wr, wr_data,
    input  hi, lo, busy, done
  );

  modport slave (
    input  op_a, op_b, op, start, hi_wr, lo_wr, wr_data,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative 32-bit multiply/divide unit with HI/LO registers.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mult_div_unit_if.slave (operands, op, start, MTHI/MTLO, hi/lo, busy, done)
// An operation takes 32 iterations on operand magnitudes plus one fix-up
// cycle that applies signs and writes hi/lo: done pulses 33 cycles after start.
module mult_div_unit (
  input  logic           clk,
  input  logic           rst,
  mult_div_unit_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]  state_reg;
  logic [5:0]  cnt_reg;
  logic        is_div_reg;
  logic        neg_res_reg;   // operand signs differ: negate product / quotient
  logic        neg_rem_reg;   // dividend negative: negate remainder
  logic        div_zero_reg;
  logic [63:0] acc_reg;       // product, or {remainder, quotient/dividend}
  logic [63:0] mcand_reg;     // multiplicand, shifted left each iteration
  logic [31:0] b_reg;         // multiplier (shifted right) or divisor
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        done_reg;

  // Operand capture terms
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // One iteration of each datapath
  logic [63:0] mul_next;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic [63:0] div_next;

  // Sign fix-up applied in FIN
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  always_comb begin
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.op_a[31];
    b_neg     = signed_op & bus.op_b[31];
    a_mag     = a_neg ? (32'd0 - bus.op_a) : bus.op_a;
    b_mag     = b_neg ? (32'd0 - bus.op_b) : bus.op_b;
  end

  always_comb begin
    mul_next = acc_reg + (b_reg[0] ? mcand_reg : 64'd0);

    // Restoring step: shift the partial remainder left, pull in the next
    // dividend bit, and keep the difference only if it did not go negative.
    // The partial remainder stays below the divisor, so 33 bits suffice.
    rem_shift = acc_reg[63:31];
    diff      = rem_shift - {1'b0, b_reg};
    if (!diff[32]) begin
      div_next = {diff[31:0], acc_reg[30:0], 1'b1};
    end else begin
      div_next = {acc_reg[62:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = neg_res_reg ? (64'd0 - acc_reg) : acc_reg;
    // Divide by zero leaves an all-ones quotient regardless of signs; the
    // remainder path already reproduces the original dividend.
    quot_fix = (neg_res_reg && !div_zero_reg) ? (32'd0 - acc_reg[31:0]) : acc_reg[31:0];
    rem_fix  = neg_rem_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 6'd0;
      is_div_reg   <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      acc_reg      <= 64'd0;
      mcand_reg    <= 64'd0;
      b_reg        <= 32'd0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            // A coincident MTHI/MTLO is dropped: start wins.
            state_reg    <= RUN;
            cnt_reg      <= 6'd0;
            is_div_reg   <= bus.op[1];
            neg_res_reg  <= a_neg ^ b_neg;
            neg_rem_reg  <= a_neg;
            div_zero_reg <= bus.op[1] & (bus.op_b == 32'd0);
            b_reg        <= b_mag;
            if (bus.op[1]) begin
              acc_reg   <= {32'd0, a_mag};
              mcand_reg <= 64'd0;
            end else begin
              acc_reg   <= 64'd0;
              mcand_reg <= {32'd0, a_mag};
            end
          end else begin
            if (bus.hi_wr) hi_reg <= bus.wr_data;
            if (bus.lo_wr) lo_reg <= bus.wr_data;
          end
        end
        RUN: begin
          if (is_div_reg) begin
            acc_reg <= div_next;
          end else begin
            acc_reg   <= mul_next;
            mcand_reg <= {mcand_reg[62:0], 1'b0};
            b_reg     <= {1'b0, b_reg[31:1]};
          end
          cnt_reg <= cnt_reg + 6'd1;
          if (cnt_reg == 6'd31) state_reg <= FIN;
        end
        FIN: begin
          if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quot_fix;
          end else begin
            hi_reg <= prod_fix[63:32];
            lo_reg <= prod_fix[31:0];
          end
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit -- directed vectors checked against an arithmetic model
// of hi/lo/busy/done every cycle, plus literal expectations per vector.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected {hi, lo} straight from the arithmetic definition of each op.
  function automatic logic [63:0] model_result(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [63:0] wa;
    logic signed [63:0] wb;
    logic [63:0] r;
    sa = a;
    sb = b;
    wa = sa;
    wb = sb;
    r  = 64'd0;
    case (op)
      2'b00: r = wa * wb;
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0)                                  r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
        else                                             r = {sa % sb, sa / sb};
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else            r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Cycle model: a request completes 33 edges after it is accepted.
  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done;
  logic [63:0] m_pend;
  int          m_left;
  bit          m_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_on = 1'b1;
    end else if (m_on) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (bus.start) begin
        m_pend = model_result(bus.op, bus.op_a, bus.op_b);
        m_left = 33;
        m_busy = 1'b1;
      end else begin
        if (bus.hi_wr) m_hi = bus.wr_data;
        if (bus.lo_wr) m_lo = bus.wr_data;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("model_hi",   bus.hi, m_hi);
      chk("model_lo",   bus.lo, m_lo);
      chk("model_busy", {31'd0, bus.busy}, {31'd0, m_busy});
      chk("model_done", {31'd0, bus.done}, {31'd0, m_done});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    while (bus.done !== 1'b1 && (cyc - start_cyc) < 40) step();
    chk({name, "_latency"}, 32'(cyc - start_cyc), 32'd33);
    chk({name, "_hi"}, bus.hi, exp_hi);
    chk({name, "_lo"}, bus.lo, exp_lo);
    $display("op %s: hi=%h lo=%h after %0d cycles", name, bus.hi, bus.lo, cyc - start_cyc);
  endtask

  initial begin
    int dones;
    bus.op = 2'b00; bus.op_a = 32'd0; bus.op_b = 32'd0; bus.start = 1'b0;
    bus.hi_wr = 1'b0; bus.lo_wr = 1'b0; bus.wr_data = 32'd0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);

    // MTHI / MTLO in idle
    bus.hi_wr = 1'b1; bus.wr_data = 32'h12345678;
    step();
    bus.hi_wr = 1'b0;
    chk("mthi", bus.hi, 32'h12345678);
    bus.lo_wr = 1'b1; bus.wr_data = 32'h0BADF00D;
    step();
    bus.lo_wr = 1'b0;
    chk("mtlo", bus.lo, 32'h0BADF00D);

    start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    wait_done("multu_max", 32'hFFFFFFFE, 32'h00000001);
    // Back-to-back: issued on the edge where done is high
    start_op(2'b00, 32'hFFFFFFFD, 32'd7);
    wait_done("mult_m3x7", 32'hFFFFFFFF, 32'hFFFFFFEB);
    start_op(2'b10, 32'd18, 32'd7);
    wait_done("div_18_7", 32'd4, 32'd2);
    start_op(2'b10, 32'hFFFFFFEE, 32'd7);
    wait_done("div_m18_7", 32'hFFFFFFFC, 32'hFFFFFFFE);
    start_op(2'b11, 32'd7, 32'd0);
    wait_done("divu_7_0", 32'd7, 32'hFFFFFFFF);
    start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_wrap", 32'd0, 32'h80000000);
    start_op(2'b10, 32'hFFFFFFFB, 32'd0);
    wait_done("div_m5_0", 32'hFFFFFFFB, 32'hFFFFFFFF);

    // Start and MTLO while busy are both ignored
    start_op(2'b01, 32'd5, 32'd6);
    repeat (9) step();
    bus.op = 2'b11; bus.op_a = 32'd9; bus.op_b = 32'd3; bus.start = 1'b1;
    bus.lo_wr = 1'b1; bus.wr_data = 32'h55555555;
    step();
    bus.start = 1'b0; bus.lo_wr = 1'b0;
    chk("lo_wr_busy", bus.lo, 32'hFFFFFFFF);
    wait_done("multu_5x6_ignored", 32'd0, 32'd30);

    // Start wins over a coincident MTHI
    bus.hi_wr = 1'b1; bus.wr_data = 32'hAAAA5555;
    start_op(2'b00, 32'h80000000, 32'h80000000);
    bus.hi_wr = 1'b0;
    wait_done("mult_min_sq", 32'h40000000, 32'h00000000);

    // Reset part-way through a divide: no result, no done
    start_op(2'b11, 32'd100, 32'd7);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    dones = 0;
    repeat (35) begin
      if (bus.done === 1'b1) dones++;
      step();
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    // Reset beats a coincident start; next edge's start is accepted
    rst = 1'b1;
    bus.op = 2'b11; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.start = 1'b1;
    step();
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_over_start_busy", {31'd0, bus.busy}, 32'd0);
    start_op(2'b11, 32'd100, 32'd7);
    wait_done("divu_100_7", 32'd2, 32'd14);
    step();
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32 bits, HI/LO 32 bits each.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports listed below, clock and reset first.
REQ-003 clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 op_a  input  32  operand A / dividend (register-file doa).
REQ-006 op_b  input  32  operand B / divisor (register-file dob).
REQ-007 op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-008 start  input  1  one-cycle request; op, op_a, op_b sampled at that edge.
REQ-009 hi_wr  input  1  MTHI: hi <= wr_data.
REQ-010 lo_wr  input  1  MTLO: lo <= wr_data.
REQ-011 wr_data  input  32  data for hi_wr/lo_wr.
REQ-012 hi  output  32  HI register (MFHI source).
REQ-013 lo  output  32  LO register (MFLO source).
REQ-014 busy  output  1  high while an operation is in progress.
REQ-015 done  output  1  one-cycle pulse when hi/lo hold a new result.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> FIN -> IDLE; busy=1 in RUN and FIN only.
REQ-017 IDLE: start=1 at edge E0 captures operands as magnitudes plus sign flags (signed ops only), clears 6-bit counter, enters RUN.
REQ-018 RUN: exactly one iteration per edge, 32 iterations (E1..E32); counter reaching 31 enters FIN.
REQ-019 Multiply SHALL be shift-add on magnitudes into a 64-bit product; signed result negated (64-bit two's complement) when sign flags differ.
REQ-020 Divide SHALL be restoring shift-subtract on magnitudes; quotient negated when signs differ; remainder takes dividend sign.
REQ-021 FIN edge E33: hi <= product[63:32] or remainder; lo <= product[31:0] or quotient; done=1 for the cycle after E33 only; busy=0 from E33; state IDLE.
REQ-022 Latency: result and done visible 33 cycles after the start edge; back-to-back start accepted on the edge where done is high.
REQ-023 start while busy SHALL be ignored (no restart, no operand capture).
REQ-024 Divide by zero (DIV or DIVU): lo=32'hFFFFFFFF, hi=op_a unchanged; full 33-cycle latency kept.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
REQ-026 hi_wr/lo_wr SHALL take effect only in IDLE; ignored while busy; if start and hi_wr/lo_wr coincide in IDLE, start wins and the write is dropped.
REQ-027 hi/lo SHALL be unchanged during RUN; only FIN, hi_wr, lo_wr, or rst modify them.

Reset
REQ-028 rst=1 at a posedge SHALL force IDLE, hi=0, lo=0, busy=0, done=0, counter=0, regardless of state.
REQ-029 rst mid-RUN SHALL abort the operation with no partial result written; a start on the first edge after rst deasserts is accepted normally.
REQ-030 rst SHALL take priority over start, hi_wr, lo_wr in the same cycle.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after start, busy high 33 cycles.
REQ-032 MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV 18/7 -> lo=2, hi=4; DIV -18/7 -> lo=0xFFFFFFFE, hi=0xFFFFFFFC.
REQ-033 DIVU 7/0 -> lo=0xFFFFFFFF, hi=7; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-034 start MULTU 5x6, second start (DIVU 9/3) at cycle 10 -> ignored; result hi=0, lo=30 at cycle 33.
REQ-035 rst at cycle 10 of DIVU 100/7 -> hi=lo=0, busy=0, no done; then DIVU 100/7 -> lo=14, hi=2.
REQ-036 hi_wr 0x12345678 in IDLE -> hi=0x12345678 next cycle; lo_wr during busy -> lo unchanged; start+hi_wr together -> hi gets result, not wr_data.
